// File: rtl/xmit_arbiter.sv
// -----------------------------------------------------------------------------
// xmit_arbiter
//   Shares the single byte-wide spi_transmitter write port between three
//   byte-stream sources (0 = metadata handler, 1 = sample readout,
//   2 = ID/status responder). One source holds the grant for a whole message.
//   Each byte is paced through the transmitter's xmit_idle handshake, so the
//   sources never look at xmit_idle themselves.
//
// Parameters
//   TIMEOUT_CYCLES : idle GRANT cycles (no accepted write) before revocation
//   TCW            : width of the timeout counter, must hold TIMEOUT_CYCLES
//
// Ports
//   clock, extReset_n     : clock (rising edge), asynchronous active-low reset
//   req[2:0]              : per-source request level, held for the message
//   wr[2:0], last[2:0]    : per-source byte strobe and end-of-message flag
//   data0/data1/data2     : per-source byte
//   gnt[2:0]              : one-hot grant, or all zero
//   ready[2:0]            : granted source may write this cycle
//   xmit_idle             : transmitter can accept a byte
//   xmit_write, xmit_data : one-cycle write strobe and byte to transmitter
//   timeout               : one-cycle pulse when a grant is revoked by timeout
//   tx_count[15:0]        : saturating count of xmit_write pulses
//
// Build option
//   XMIT_ARB_STATS_EN : when defined, tx_count counts bytes sent; otherwise it
//                       is tied to zero and no counter is built.
// -----------------------------------------------------------------------------
module xmit_arbiter #(
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int TCW            = 11
) (
   input  logic        clock,
   input  logic        extReset_n,
   input  logic [2:0]  req,
   input  logic [2:0]  wr,
   input  logic [2:0]  last,
   input  logic [7:0]  data0,
   input  logic [7:0]  data1,
   input  logic [7:0]  data2,
   output logic [2:0]  gnt,
   output logic [2:0]  ready,
   input  logic        xmit_idle,
   output logic        xmit_write,
   output logic [7:0]  xmit_data,
   output logic        timeout,
   output logic [15:0] tx_count
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_GRANT   = 3'd1,
      S_SEND    = 3'd2,
      S_HOLDOFF = 3'd3,
      S_WAIT    = 3'd4
   } state_t;

   localparam logic [TCW-1:0] TO_MAX  = TCW'(TIMEOUT_CYCLES);
   localparam logic [TCW-1:0] TO_LAST = TCW'(TIMEOUT_CYCLES - 1);

   // Modulo-3 increment; rr_ptr only ever holds 0..2.
   function automatic logic [1:0] inc3(input logic [1:0] v);
      return (v == 2'd2) ? 2'd0 : v + 2'd1;
   endfunction

   state_t         state_q, state_d;
   logic [2:0]     gnt_q, gnt_d;
   logic [1:0]     rr_q, rr_d;
   logic [7:0]     hold_q, hold_d;
   logic           last_q, last_d;
   logic [TCW-1:0] cnt_q, cnt_d;
   logic           tmo_q, tmo_d;

   logic [1:0]     c0, c1, c2, pick_idx;
   logic           pick_vld;
   logic           acc;
   logic           req_g;
   logic [7:0]     gdata;

   // Round-robin search starting at rr_ptr.
   always_comb begin
      c0       = rr_q;
      c1       = inc3(rr_q);
      c2       = inc3(c1);
      pick_vld = |req;
      if (req[c0])      pick_idx = c0;
      else if (req[c1]) pick_idx = c1;
      else              pick_idx = c2;
   end

   always_comb begin
      if (gnt_q[0])      gdata = data0;
      else if (gnt_q[1]) gdata = data1;
      else               gdata = data2;
   end

   assign req_g = |(req & gnt_q);
   assign acc   = (state_q == S_GRANT) && xmit_idle && (|(wr & gnt_q));

   always_ff @(posedge clock or negedge extReset_n) begin
      if (!extReset_n) begin
         state_q <= S_IDLE;
         gnt_q   <= '0;
         rr_q    <= '0;
         hold_q  <= '0;
         last_q  <= 1'b0;
         cnt_q   <= '0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         rr_q    <= rr_d;
         hold_q  <= hold_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         tmo_q   <= tmo_d;
      end
   end

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      rr_d    = rr_q;
      hold_d  = hold_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      tmo_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (pick_vld) begin
               gnt_d   = 3'b001 << pick_idx;
               rr_d    = inc3(pick_idx);
               cnt_d   = '0;
               state_d = S_GRANT;
            end
         end
         S_GRANT: begin
            // An accepted write beats both drop-out and timeout.
            if (acc) begin
               hold_d  = gdata;
               last_d  = |(last & gnt_q);
               state_d = S_SEND;
            end else if (!req_g) begin
               gnt_d   = '0;
               state_d = S_IDLE;
            end else if (cnt_q >= TO_LAST) begin
               // This is the TIMEOUT_CYCLES-th idle cycle: revoke now so the
               // pulse and the cleared grant appear together next cycle.
               cnt_d   = TO_MAX;
               gnt_d   = '0;
               tmo_d   = 1'b1;
               state_d = S_IDLE;
            end else begin
               cnt_d   = cnt_q + TCW'(1);
            end
         end
         S_SEND:    state_d = S_HOLDOFF;
         // xmit_idle may still read 1 right after a write, so skip one cycle.
         S_HOLDOFF: state_d = S_WAIT;
         S_WAIT: begin
            if (xmit_idle) begin
               if (last_q) begin
                  gnt_d   = '0;
                  state_d = S_IDLE;
               end else begin
                  cnt_d   = '0;
                  state_d = S_GRANT;
               end
            end
         end
         default: begin
            gnt_d   = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   assign gnt        = gnt_q;
   assign ready      = ((state_q == S_GRANT) && xmit_idle) ? gnt_q : 3'b000;
   assign xmit_write = (state_q == S_SEND);
   assign xmit_data  = xmit_write ? hold_q : 8'h00;
   assign timeout    = tmo_q;

`ifdef XMIT_ARB_STATS_EN
   logic [15:0] txc_q;

   always_ff @(posedge clock or negedge extReset_n) begin
      if (!extReset_n) begin
         txc_q <= '0;
      end else if (xmit_write && (txc_q != 16'hFFFF)) begin
         txc_q <= txc_q + 16'd1;
      end
   end

   assign tx_count = txc_q;
`else
   assign tx_count = 16'h0000;
`endif

endmodule

// File: tb/tb_xmit_arbiter.sv
// -----------------------------------------------------------------------------
// tb_xmit_arbiter
//   Directed bench for xmit_arbiter: single-source message, round-robin order,
//   grant timeout, back-pressure, reset mid-message and the byte counter.
//   A small transmitter model drops xmit_idle for busy_len cycles after each
//   write; a monitor logs every xmit_write and timeout pulse with its cycle.
// -----------------------------------------------------------------------------
module tb_xmit_arbiter;

   localparam int TO = 8;
`ifdef XMIT_ARB_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic        clock      = 1'b0;
   logic        extReset_n = 1'b0;
   logic [2:0]  req  = '0;
   logic [2:0]  wr   = '0;
   logic [2:0]  last = '0;
   logic [7:0]  data0 = '0, data1 = '0, data2 = '0;
   logic [2:0]  gnt, ready;
   logic        xmit_idle, xmit_write, timeout;
   logic [7:0]  xmit_data;
   logic [15:0] tx_count;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   int   busy     = 0;
   int   busy_len = 0;
   logic hold_low = 1'b0;
   logic gnt_bad  = 1'b0;

   int         pq_cyc[$];
   logic [7:0] pq_dat[$];
   int         tq[$];

   xmit_arbiter #(.TIMEOUT_CYCLES(TO), .TCW(4)) dut (
      .clock      (clock),
      .extReset_n (extReset_n),
      .req        (req),
      .wr         (wr),
      .last       (last),
      .data0      (data0),
      .data1      (data1),
      .data2      (data2),
      .gnt        (gnt),
      .ready      (ready),
      .xmit_idle  (xmit_idle),
      .xmit_write (xmit_write),
      .xmit_data  (xmit_data),
      .timeout    (timeout),
      .tx_count   (tx_count)
   );

   always #5 clock = ~clock;

   // Transmitter model: busy for busy_len cycles after each accepted byte.
   always @(posedge clock) begin
      cyc <= cyc + 1;
      if (xmit_write)    busy <= busy_len;
      else if (busy > 0) busy <= busy - 1;
   end

   assign xmit_idle = !hold_low && (busy == 0);

   always @(negedge clock) begin
      if (extReset_n) begin
         if (xmit_write) begin
            pq_cyc.push_back(cyc);
            pq_dat.push_back(xmit_data);
         end
         if (timeout) tq.push_back(cyc);
         if (!$onehot0(gnt)) gnt_bad <= 1'b1;
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   function automatic int gidx(input logic [2:0] g);
      return g[2] ? 2 : (g[1] ? 1 : 0);
   endfunction

   task automatic set_src(input int s, input logic w, input logic l, input logic [7:0] d);
      wr[s]   = w;
      last[s] = l;
      case (s)
         0:       data0 = d;
         1:       data1 = d;
         default: data2 = d;
      endcase
   endtask

   task automatic do_reset();
      extReset_n = 1'b0;
      req = '0; wr = '0; last = '0; hold_low = 1'b0;
      step();
      step();
      extReset_n = 1'b1;
      step();
   endtask

   task automatic wait_gnt(input logic [2:0] want, input string tag);
      int k;
      k = 0;
      while (gnt !== want && k < 100) begin
         step();
         k++;
      end
      check(tag, gnt, want);
   endtask

   task automatic wait_any_gnt(output int ec);
      int k;
      k = 0;
      while (gnt == 3'b000 && k < 100) begin
         step();
         k++;
      end
      ec = cyc;
      check("grant_seen", |gnt, 1);
   endtask

   // Waits for ready[s], presents one byte for one cycle; acc = accept cycle.
   task automatic send_byte(input int s, input logic [7:0] d, input logic l,
                            input logic drop, output int acc);
      int k;
      k   = 0;
      acc = -1;
      while (!ready[s] && k < 100) begin
         step();
         k++;
      end
      if (!ready[s]) begin
         check("ready_wait", ready[s], 1);
         return;
      end
      set_src(s, 1'b1, l, d);
      acc = cyc;
      step();
      set_src(s, 1'b0, 1'b0, 8'h00);
      if (l && drop) req[s] = 1'b0;
   endtask

   initial begin
      int         a[5];
      int         ac, ec, base, tbase;
      logic [7:0] md[3];
      logic [2:0] rr_exp[4];
      md     = '{8'h01, 8'h4F, 8'h00};
      rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001};

      // Reset values
      step();
      step();
      check("rst_gnt",   gnt, 0);
      check("rst_ready", ready, 0);
      check("rst_write", xmit_write, 0);
      check("rst_data",  xmit_data, 0);
      check("rst_tmo",   timeout, 0);
      check("rst_txc",   tx_count, 0);
      extReset_n = 1'b1;
      step();

      // Metadata message, transmitter busy 5 cycles after each byte
      busy_len = 5;
      base = pq_cyc.size();
      req = 3'b001;
      wait_gnt(3'b001, "meta_gnt");
      send_byte(0, 8'h01, 1'b0, 1'b1, a[0]);
      send_byte(0, 8'h4F, 1'b0, 1'b1, a[1]);
      check("meta_gnt_hold", gnt, 3'b001);
      send_byte(0, 8'h00, 1'b1, 1'b1, a[2]);
      wait_gnt(3'b000, "meta_release");
      check("meta_count", pq_cyc.size() - base, 3);
      if (pq_cyc.size() >= base + 3) begin
         for (int i = 0; i < 3; i++) begin
            check($sformatf("meta_data%0d", i), pq_dat[base+i], md[i]);
            check($sformatf("meta_lat%0d", i),  pq_cyc[base+i], a[i] + 1);
         end
      end

      // Round robin with req held on all three sources
      do_reset();
      busy_len = 0;
      req = 3'b111;
      for (int i = 0; i < 4; i++) begin
         wait_any_gnt(ec);
         check($sformatf("rr_order%0d", i), gnt, rr_exp[i]);
         send_byte(gidx(gnt), 8'h10 + 8'(i), 1'b1, 1'b0, ac);
         if (i == 3) req = 3'b000;
         wait_gnt(3'b000, $sformatf("rr_release%0d", i));
      end

      // Timeout on source 1, then source 2 granted
      do_reset();
      busy_len = 0;
      tbase = tq.size();
      req = 3'b110;
      wait_any_gnt(ec);
      check("to_gnt1", gnt, 3'b010);
      repeat (7) step();
      check("to_hold",  gnt, 3'b010);
      check("to_quiet", timeout, 0);
      step();
      check("to_pulse",   timeout, 1);
      check("to_gnt_clr", gnt, 3'b000);
      step();
      check("to_next_gnt",  gnt, 3'b100);
      check("to_pulse_end", timeout, 0);
      check("to_once", tq.size() - tbase, 1);
      if (tq.size() > tbase) check("to_cycle", tq[tbase], ec + TO);

      // Back-pressure on source 2
      base = pq_cyc.size();
      hold_low = 1'b1;
      req = 3'b100;
      for (int i = 0; i < 4; i++) begin
         set_src(2, (i % 2) == 0, 1'b1, 8'hA5);
         #1;
         check($sformatf("bp_ready%0d", i), ready, 3'b000);
         step();
      end
      set_src(2, 1'b0, 1'b0, 8'h00);
      check("bp_no_write", pq_cyc.size() - base, 0);
      hold_low = 1'b0;
      set_src(0, 1'b1, 1'b0, 8'h77);
      #1;
      send_byte(2, 8'hA5, 1'b1, 1'b1, ac);
      set_src(0, 1'b0, 1'b0, 8'h00);
      wait_gnt(3'b000, "bp_release");
      check("bp_count", pq_cyc.size() - base, 1);
      if (pq_cyc.size() > base) begin
         check("bp_data", pq_dat[base], 8'hA5);
         check("bp_lat",  pq_cyc[base], ac + 1);
      end

      // Reset asserted during WAIT of a 4-byte message
      do_reset();
      busy_len = 6;
      req = 3'b001;
      wait_gnt(3'b001, "mr_gnt");
      send_byte(0, 8'hC1, 1'b0, 1'b1, ac);
      send_byte(0, 8'hC2, 1'b0, 1'b1, ac);
      step();
      step();
      check("mr_wait_ready", ready, 3'b000);
      #2;
      extReset_n = 1'b0;
      #1;
      check("mr_gnt0",   gnt, 0);
      check("mr_ready0", ready, 0);
      check("mr_write0", xmit_write, 0);
      check("mr_data0",  xmit_data, 0);
      check("mr_tmo0",   timeout, 0);
      check("mr_txc0",   tx_count, 0);
      base = pq_cyc.size();
      req = 3'b000;
      step();
      step();
      extReset_n = 1'b1;
      repeat (20) step();
      check("mr_no_write", pq_cyc.size() - base, 0);
      check("mr_idle_gnt", gnt, 0);
      req = 3'b010;
      wait_gnt(3'b010, "mr_regrant");
      send_byte(1, 8'h5A, 1'b1, 1'b1, ac);
      wait_gnt(3'b000, "mr_release");
      check("mr_new_count", pq_cyc.size() - base, 1);
      if (pq_cyc.size() > base) check("mr_new_data", pq_dat[base], 8'h5A);

      // Byte counter and back-to-back throughput
      do_reset();
      busy_len = 0;
      check("stats_clr", tx_count, 0);
      req = 3'b001;
      wait_gnt(3'b001, "stats_gnt");
      for (int i = 0; i < 5; i++)
         send_byte(0, 8'h20 + 8'(i), i == 4, 1'b1, a[i]);
      wait_gnt(3'b000, "stats_release");
      check("stats_count", tx_count, STATS ? 5 : 0);
      check("thru_gap0", a[1] - a[0], 4);
      check("thru_gap3", a[4] - a[3], 4);

      check("gnt_onehot", gnt_bad, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/xmit_arbiter.md
Name: xmit_arbiter

Overview:
- Shares the single byte-wide spi_transmitter write port between three byte-stream sources: requester 0 = metadata handler, 1 = sample readout, 2 = ID/status responder.
- Grants one source at a time, with the grant locked for a whole message.
- Sequences each byte through the transmitter's xmit_idle handshake, so sources no longer poll xmit_idle themselves.
- Sits between the command decoder sources and spi_transmitter.

Parameters:
- TIMEOUT_CYCLES, 1024: idle cycles allowed in GRANT with no write before the grant is revoked.
- TCW, 11: width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clock  in  1  system clock; all state on rising edge
- extReset_n  in  1  asynchronous, active-low reset
- req  in  3  per-source request, level; held for the whole message
- wr  in  3  per-source byte strobe; honoured only when ready[i]=1
- last  in  3  qualifies wr[i]: this byte ends the message
- data0  in  8  byte from source 0
- data1  in  8  byte from source 1
- data2  in  8  byte from source 2
- gnt  out  3  one-hot grant, or all zero
- ready  out  3  source i may write this cycle
- xmit_idle  in  1  transmitter can accept a byte
- xmit_write  out  1  single-cycle write strobe to transmitter
- xmit_data  out  8  byte to transmitter, valid while xmit_write=1
- timeout  out  1  single-cycle pulse when a grant is revoked by timeout
- tx_count  out  16  bytes sent (see Optional Feature)

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values: state=IDLE, gnt=0, ready=0, xmit_write=0, xmit_data=0, timeout=0, tx_count=0, rr_ptr=0, holding register=0, last_flag=0, counter=0.
- Reset asserted mid-message aborts the message immediately; no further xmit_write until a fresh grant.
- States: IDLE, GRANT, SEND, HOLDOFF, WAIT.
- IDLE:
  - If any req is set, grant the first requesting index at or after rr_ptr, in order rr_ptr, rr_ptr+1, rr_ptr+2 mod 3.
  - gnt becomes valid the next cycle. Go to GRANT.
  - rr_ptr is set to (granted index + 1) mod 3.
- GRANT:
  - ready[g] = xmit_idle; all other ready bits are 0.
  - wr[g] with ready[g]: latch data_g into the holding register, latch last[g] into last_flag, go to SEND.
  - wr on a non-granted source, or wr[g] while ready[g]=0, is ignored.
  - req[g] deasserted with no accepted write: go to IDLE and clear gnt (drop-out). If wr is accepted in the same cycle, the write wins.
  - Counter counts cycles with no accepted write. When it reaches TIMEOUT_CYCLES: pulse timeout, clear gnt, go to IDLE.
- SEND:
  - xmit_write=1 for exactly one cycle; xmit_data = holding register.
  - Latency: wr accepted in cycle N gives xmit_write in cycle N+1.
  - Go to HOLDOFF.
- HOLDOFF:
  - One cycle; xmit_idle is ignored, because the transmitter may still report idle in the cycle after a write.
  - Go to WAIT.
- WAIT:
  - ready=0. Stay until xmit_idle=1.
  - Then: if last_flag=1, clear gnt and go to IDLE; otherwise go to GRANT with the counter cleared.
- Throughput: at most one byte every 4 cycles when the transmitter is instantly idle.
- gnt stays constant from grant to release. gnt is never nonzero in IDLE.
- A requester that keeps req high after last competes again, round-robin, from IDLE.
- Width rules:
  - The counter saturates at TIMEOUT_CYCLES and does not wrap.
  - rr_ptr is 2 bits and holds only values 0–2.

Optional Feature:
- XMIT_ARB_STATS_EN defined:
  - tx_count increments on every xmit_write pulse.
  - It saturates at 16'hFFFF and clears only on reset.
- Undefined:
  - tx_count is tied to 0 and no counter logic is built.
  - The port is still present.

Test Plan:
- Meta message: req=001; source 0 writes 3 bytes 0x01, 0x4F, 0x00 (last on 0x00); xmit_idle drops for 5 cycles after each write.
  - Expect 3 xmit_write pulses with data 0x01, 0x4F, 0x00.
  - Each pulse lands 1 cycle after its accepted wr.
  - gnt returns to 000 after the third byte completes.
- Round-robin: req=111 held; each source sends a 1-byte message with last=1.
  - Grant order is 0, 1, 2, 0; gnt is never multi-hot.
- Timeout: TIMEOUT_CYCLES=8; source 1 is granted but never writes.
  - Exactly 8 cycles after GRANT entry: timeout pulses once and gnt=000.
  - If source 2 is requesting, it is granted next.
- Back-pressure: xmit_idle held 0 while source 2 is granted and pulses wr.
  - ready=0; no byte is accepted; no xmit_write occurs.
  - Raising xmit_idle accepts the next wr.
- Reset mid-message: assert extReset_n=0 during WAIT of a 4-byte message.
  - All outputs go to 0 asynchronously.
  - After release, no xmit_write occurs until a new req is granted.
- Stats: with XMIT_ARB_STATS_EN, send 5 bytes: tx_count=5. Without it: tx_count=0.
